// File: rtl/line_tap_buffer_pkg.sv
// Shared types and width helpers for the line tap buffer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ltb_pkg;

  typedef enum logic {
    LTB_FILL = 1'b0,
    LTB_RUN  = 1'b1
  } ltb_state_t;

  // Bits needed to hold 0..n-1, never less than 1 so n=1/2 still yields a legal vector.
  function automatic int ltb_clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/line_tap_buffer_line_ram.sv
// One image row of storage, indexed by column.
// Latency: read returns the stored word in the access cycle; write lands on the clock edge.
// Backpressure: none; the caller only asserts we on accepted samples.
module line_ram #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [LINE_LEN];

  // Read sees the word as it was before this cycle's write (read-before-write).
  assign rdata = mem_q[addr];

  // Write the new word at the current column; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/line_tap_buffer.sv
// Multi-row delay buffer: current pixel plus NUM_TAPS pixels from rows above, same column.
// Latency: 1 cycle from accepted sample to out_valid/out_cur/out_taps.
// Backpressure: in_valid low stalls everything (outputs hold, out_valid drops); no ready.
// Optional top-border zero padding is enabled with `define LINE_TAP_ZERO_FILL_EN.
module line_tap_buffer
  import ltb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 256,
  parameter int NUM_TAPS = 2,
  localparam int ADDR_W  = ltb_clog2_min1(LINE_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_cur,
  output logic [NUM_TAPS*DATA_W-1:0]   out_taps,
  output logic                         primed
);

  localparam int ROWS_W = ltb_clog2_min1(NUM_TAPS + 1);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(LINE_LEN - 1);
  localparam logic [ROWS_W-1:0] ROWS_FULL = ROWS_W'(NUM_TAPS);
  localparam logic [ROWS_W-1:0] ROWS_LAST = ROWS_W'(NUM_TAPS - 1);

  ltb_state_t                state_q, state_d;
  logic [ADDR_W-1:0]         col_q, col_d;
  logic [ROWS_W-1:0]         rows_q, rows_d;
  logic                      vld_q, vld_d;
  logic [DATA_W-1:0]         cur_q, cur_d;
  logic [NUM_TAPS*DATA_W-1:0] taps_q, taps_d;

  logic accept;
  logic wrap;
  logic [DATA_W-1:0] rd_word  [NUM_TAPS];
  logic [DATA_W-1:0] tap_word [NUM_TAPS];
  logic [DATA_W-1:0] wr_word  [NUM_TAPS];

  assign accept = in_valid & ~flush;
  assign wrap   = accept && (col_q == COL_LAST);

  // Chain of row memories: row k shifts its old word into row k+1 at the same column.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_line
`ifdef LINE_TAP_ZERO_FILL_EN
    // Rows not yet written since reset/flush read as zero (top-border padding).
    assign tap_word[k] = (rows_q > ROWS_W'(k)) ? rd_word[k] : '0;
`else
    assign tap_word[k] = rd_word[k];
`endif
    if (k == 0) begin : g_head
      assign wr_word[k] = in_data;
    end else begin : g_chain
      assign wr_word[k] = tap_word[k-1];
    end

    line_ram #(
      .DATA_W  (DATA_W),
      .LINE_LEN(LINE_LEN),
      .ADDR_W  (ADDR_W)
    ) u_line (
      .clk  (clk),
      .we   (accept),
      .addr (col_q),
      .wdata(wr_word[k]),
      .rdata(rd_word[k])
    );
  end

  // Next-state for column/row counters, FILL->RUN transition and output registers.
  always_comb begin
    col_d   = col_q;
    rows_d  = rows_q;
    state_d = state_q;
    vld_d   = 1'b0;
    cur_d   = cur_q;
    taps_d  = taps_q;
    if (flush) begin
      col_d   = '0;
      rows_d  = '0;
      state_d = LTB_FILL;
      cur_d   = '0;
      taps_d  = '0;
    end else if (in_valid) begin
      col_d = wrap ? '0 : col_q + ADDR_W'(1);
      if (wrap && (rows_q != ROWS_FULL)) rows_d = rows_q + ROWS_W'(1);
      case (state_q)
        LTB_FILL: if (wrap && (rows_q == ROWS_LAST)) state_d = LTB_RUN;
        LTB_RUN:  state_d = LTB_RUN;
        default:  state_d = LTB_FILL;
      endcase
`ifdef LINE_TAP_ZERO_FILL_EN
      vld_d = 1'b1;
`else
      vld_d = (state_q == LTB_RUN);
`endif
      cur_d = in_data;
      for (int k = 0; k < NUM_TAPS; k++) begin
        taps_d[k*DATA_W +: DATA_W] = tap_word[k];
      end
    end
  end

  // State and output registers; async reset returns everything to the empty buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LTB_FILL;
      col_q   <= '0;
      rows_q  <= '0;
      vld_q   <= 1'b0;
      cur_q   <= '0;
      taps_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      vld_q   <= vld_d;
      cur_q   <= cur_d;
      taps_q  <= taps_d;
    end
  end

  assign out_valid = vld_q;
  assign out_cur   = cur_q;
  assign out_taps  = taps_q;
  assign primed    = (state_q == LTB_RUN);

endmodule

// File: tb/tb_line_tap_buffer.sv
module tb_line_tap_buffer;

  localparam int L = 4;
  localparam int T = 2;
  localparam int BL = 256;
`ifdef LINE_TAP_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush, in_valid;
  logic [7:0] in_data;
  logic out_valid, primed;
  logic [7:0] out_cur;
  logic [15:0] out_taps;

  logic b_valid;
  logic [7:0] b_data;
  logic b_out_valid, b_primed;
  logic [7:0] b_out_cur;
  logic [15:0] b_out_taps;

  always #5 clk = ~clk;

  line_tap_buffer #(.DATA_W(8), .LINE_LEN(L), .NUM_TAPS(T)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_cur(out_cur), .out_taps(out_taps), .primed(primed)
  );

  line_tap_buffer dut_big (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(b_valid), .in_data(b_data),
    .out_valid(b_out_valid), .out_cur(b_out_cur), .out_taps(b_out_taps), .primed(b_primed)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  cur;
    logic [15:0] taps;
    logic [1:0]  tmask;
    logic        prm;
    logic        prm_chk;
  } exp_t;

  exp_t sb[$];
  exp_t sb_big[$];
  int checks = 0;
  int failures = 0;

  logic [7:0]  hs [0:255];
  int          hn = 0;
  logic [7:0]  m_cur = '0;
  logic [15:0] m_taps = '0;
  logic [1:0]  m_mask = 2'b11;

  task automatic model_clear();
    hn = 0; m_cur = '0; m_taps = '0; m_mask = 2'b11;
  endtask

  // One clock of stimulus on the small DUT, with the expectation pushed and checked.
  task automatic cycle(input string nm, input bit v, input logic [7:0] x, input bit fl);
    exp_t e, g;
    int n;
    in_valid = v; in_data = x; flush = fl;
    e.prm_chk = 1'b1;
    if (fl) begin
      hn = 0;
      e.vld = 1'b0; e.cur = '0; e.taps = '0; e.tmask = 2'b11; e.prm = 1'b0;
    end else if (v) begin
      n = hn; hs[n] = x; hn++;
      e.vld = ZF || (n >= T*L);
      e.cur = x; e.taps = '0; e.tmask = 2'b00;
      for (int k = 1; k <= T; k++) begin
        if (n >= k*L) begin
          e.taps[(k-1)*8 +: 8] = hs[n-k*L]; e.tmask[k-1] = 1'b1;
        end else if (ZF) begin
          e.tmask[k-1] = 1'b1;
        end
      end
      e.prm = (hn >= T*L);
      e.prm_chk = (hn != T*L);
    end else begin
      e.vld = 1'b0; e.cur = m_cur; e.taps = m_taps; e.tmask = m_mask; e.prm = (hn >= T*L);
    end
    m_cur = e.cur; m_taps = e.taps; m_mask = e.tmask;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    checks++;
    if (out_valid !== g.vld) begin
      failures++; $display("FAIL %s out_valid got %0b exp %0b", nm, out_valid, g.vld);
    end
    checks++;
    if (out_cur !== g.cur) begin
      failures++; $display("FAIL %s out_cur got %0d exp %0d", nm, out_cur, g.cur);
    end
    for (int k = 0; k < T; k++) begin
      if (g.tmask[k]) begin
        checks++;
        if (out_taps[k*8 +: 8] !== g.taps[k*8 +: 8]) begin
          failures++;
          $display("FAIL %s tap%0d got %0d exp %0d", nm, k+1, out_taps[k*8 +: 8], g.taps[k*8 +: 8]);
        end
      end
    end
    if (g.prm_chk) begin
      checks++;
      if (primed !== g.prm) begin
        failures++; $display("FAIL %s primed got %0b exp %0b", nm, primed, g.prm);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); flush = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, primed, out_cur, out_taps} !== 26'd0 ||
          {b_out_valid, b_primed, b_out_cur, b_out_taps} !== 26'd0) begin
        failures++;
        $display("FAIL reset outputs got vld=%0b prm=%0b cur=%0d taps=%h exp all zero",
                 out_valid, primed, out_cur, out_taps);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 12; i++) cycle("ramp", 1'b1, 8'(i), 1'b0);
    cycle("ramp_idle", 1'b0, 8'hAA, 1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) cycle("stall_pre", 1'b1, 8'(i), 1'b0);
    cycle("stall_gap", 1'b0, 8'hEE, 1'b0);
    cycle("stall_gap", 1'b0, 8'hEF, 1'b0);
    cycle("stall_post", 1'b1, 8'd10, 1'b0);
    cycle("stall_post", 1'b1, 8'd11, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) cycle("flush_pre", 1'b1, 8'(i), 1'b0);
    cycle("flush_hit", 1'b1, 8'd10, 1'b1);
    for (int i = 20; i <= 29; i++) cycle("flush_post", 1'b1, 8'(i), 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle("areset_pre", 1'b1, 8'(i), 1'b0);
    in_valid = 1'b1; in_data = 8'd6; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, primed, out_cur, out_taps} !== 26'd0) begin
      failures++;
      $display("FAIL async_reset got vld=%0b prm=%0b cur=%0d taps=%h exp all zero",
               out_valid, primed, out_cur, out_taps);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    model_clear();
    for (int i = 0; i < 12; i++) cycle("areset_ramp", 1'b1, 8'(i), 1'b0);
  endtask

  function automatic logic [7:0] bf(input int i);
    return 8'((i + 3 * (i / BL)) & 255);
  endfunction

  // Three full 256-pixel rows through the default-sized instance, crossing the 255->0 wrap.
  task automatic test_long_row();
    exp_t e, g;
    for (int i = 0; i < 3*BL + 4; i++) begin
      b_valid = 1'b1; b_data = bf(i);
      e.vld = ZF || (i >= 2*BL);
      e.cur = bf(i);
      e.taps = '0; e.tmask = 2'b00;
      for (int k = 1; k <= 2; k++) begin
        if (i >= k*BL) begin
          e.taps[(k-1)*8 +: 8] = bf(i - k*BL); e.tmask[k-1] = 1'b1;
        end else if (ZF) e.tmask[k-1] = 1'b1;
      end
      e.prm = (i + 1 >= 2*BL);
      e.prm_chk = (i + 1 != 2*BL);
      sb_big.push_back(e);
      @(negedge clk);
      g = sb_big.pop_front();
      checks++;
      if (b_out_valid !== g.vld) begin
        failures++; $display("FAIL long_row[%0d] out_valid got %0b exp %0b", i, b_out_valid, g.vld);
      end
      if (g.vld) begin
        checks++;
        if (b_out_cur !== g.cur) begin
          failures++; $display("FAIL long_row[%0d] out_cur got %0d exp %0d", i, b_out_cur, g.cur);
        end
        for (int k = 0; k < 2; k++) begin
          if (g.tmask[k]) begin
            checks++;
            if (b_out_taps[k*8 +: 8] !== g.taps[k*8 +: 8]) begin
              failures++;
              $display("FAIL long_row[%0d] tap%0d got %0d exp %0d", i, k+1,
                       b_out_taps[k*8 +: 8], g.taps[k*8 +: 8]);
            end
          end
        end
      end
      if (g.prm_chk) begin
        checks++;
        if (b_primed !== g.prm) begin
          failures++; $display("FAIL long_row[%0d] primed got %0b exp %0b", i, b_primed, g.prm);
        end
      end
    end
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    b_valid = 1'b0; b_data = '0;
    test_reset();
    test_ramp();
    test_reset();
    test_stall();
    test_reset();
    test_flush();
    test_reset();
    test_async_reset();
    test_reset();
    test_long_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
